mult_share_arb: RTL and testbench

Round-robin arbiter and two-stage issue pipeline that shares one unsigned W×W array multiplier among N_REQ requesters. Each requester presents operands with a valid/ready handshake. Results return on a single tagged response channel with backpressure. The block sits between the datapath clients and the combinational multiplier, and is the only path by which clients reach it.

---
 rtl/mult_share_pkg.sv | 38 +++
 rtl/mult_array.sv | 48 ++++
 rtl/mult_share_arb.sv | 112 +++++++++++
 tb/tb_mult_share_arb.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: default widths
// and the round-robin grant picker.
package mult_share_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 4;
    localparam int ID_W_DEF  = 2;

    // The picker works on a fixed 8-lane vector (the largest supported
    // requester count). Callers zero-extend their valid vector and pointer.
    localparam int N_MAX = 8;
    localparam int PTR_W = 3;

    // One-hot grant to the first valid lane at or above ptr, wrapping at n.
    function automatic logic [N_MAX-1:0] rr_pick(
        input logic [N_MAX-1:0] valid,
        input logic [PTR_W-1:0] ptr,
        input int               n
    );
        logic [N_MAX-1:0] grant;
        logic             found;
        logic [PTR_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_MAX; k++) begin
            if (k < n) begin
                idx = PTR_W'((int'(ptr) + k) % n);
                if (!found && valid[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/mult_array.sv
// Combinational unsigned W x W -> 2W array multiplier. Row 0 is the plain
// partial-product row; every following row is a ripple of full-adder cells
// that folds the next shifted partial product into the running sum.
module mult_array #(
    parameter int W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    logic [2*W-1:0] acc;
    logic           carry;
    logic           x;
    logic           y;
    logic           s;

    // Full-adder cell: returns {carry_out, sum}. With cin tied low it acts
    // as a half adder.
    function automatic logic [1:0] full_add(input logic fa, input logic fb, input logic cin);
        return {(fa & fb) | (cin & (fa ^ fb)), fa ^ fb ^ cin};
    endfunction

    // Accumulate shifted partial-product rows through the adder array.
    always_comb begin
        acc   = '0;
        carry = 1'b0;
        x     = 1'b0;
        y     = 1'b0;
        s     = 1'b0;
        for (int j = 0; j < W; j++) begin
            acc[j] = a[j] & b[0];
        end
        for (int i = 1; i < W; i++) begin
            carry = 1'b0;
            for (int j = 0; j < W; j++) begin
                x            = acc[i+j];
                y            = a[j] & b[i];
                {carry, s}   = full_add(x, y, carry);
                acc[i+j]     = s;
            end
            // Bit i+W is still zero here, so the row carry lands in it cleanly.
            acc[i+W] = carry;
        end
        p = acc;
    end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter plus two-stage issue pipeline sharing one array
// multiplier among N_REQ requesters, with a tagged, backpressured response.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. A requester holds valid and its operands stable until that
// edge; ready may depend combinationally on valid, never the reverse. The
// response side holds rsp_valid/rsp_id/rsp_product steady until rsp_ready.
module mult_share_arb
    import mult_share_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [2*W-1:0]       rsp_product,
    output logic [15:0]          op_count
);

    logic [ID_W-1:0]  ptr;
    logic             s1_v;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [ID_W-1:0]  s1_id;
    logic             s2_v;
    logic [2*W-1:0]   prod;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  gidx;
    logic             adv1;
    logic             load1;
    logic             accept;

    // Pipeline advance terms, round-robin grant and the accept qualifier.
    always_comb begin
        adv1      = s1_v & (~s2_v | rsp_ready);
        load1     = ~s1_v | adv1;
        grant     = N_REQ'(rr_pick(N_MAX'(req_valid), PTR_W'(ptr), N_REQ));
        req_ready = load1 ? grant : '0;
        accept    = |(req_valid & req_ready);
        gidx      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gidx = ID_W'(i);
            end
        end
    end

    // Stage 1 issue register and round-robin pointer; the pointer only
    // moves past a requester once it has actually been accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_id <= '0;
            ptr   <= '0;
        end else begin
            if (load1) begin
                s1_v <= accept;
                if (accept) begin
                    s1_a  <= req_a[int'(gidx)*W +: W];
                    s1_b  <= req_b[int'(gidx)*W +: W];
                    s1_id <= gidx;
                end
            end
            if (accept) begin
                ptr <= (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + ID_W'(1);
            end
        end
    end

    mult_array #(.W(W)) u_mult (
        .a (s1_a),
        .b (s1_b),
        .p (prod)
    );

    // Stage 2 result register; reloads in the same cycle it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v        <= 1'b0;
            rsp_id      <= '0;
            rsp_product <= '0;
        end else if (adv1) begin
            s2_v        <= 1'b1;
            rsp_id      <= s1_id;
            rsp_product <= prod;
        end else if (rsp_ready) begin
            s2_v        <= 1'b0;
        end
    end

    // Completed-response counter, free-running with natural 16-bit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (s2_v & rsp_ready) begin
            op_count <= op_count + 16'd1;
        end
    end

    assign rsp_valid = s2_v;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: a vector table of single requests
// plus hand-written multi-cycle sequences (concurrency, stall, fairness,
// reset in flight, counter wrap) checked against a response scoreboard.
module tb_mult_share_arb;

    localparam int NR = 4;
    localparam int W  = 4;
    localparam int IW = 2;
    localparam int EW = IW + 2*W;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*W-1:0] req_a;
    logic [NR*W-1:0] req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [2*W-1:0]  rsp_product;
    logic [15:0]     op_count;

    mult_share_arb #(.N_REQ(NR), .W(W), .ID_W(IW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .op_count    (op_count)
    );

    typedef struct {
        int             id;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
    } vec_t;

    vec_t          vecs[6];
    logic [EW-1:0] exp_q[$];
    int            grant_q[$];
    int            acc_cyc_q[$];
    int            rsp_cyc_q[$];
    int            n_tests;
    int            n_fail;
    int            cyc;
    int            acc_cnt;
    int            base;
    logic          bulk;
    logic [NR-1:0] acc_mask_last;
    logic [NR-1:0] mon_acc;
    logic [EW-1:0] mon_exp;

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Advance one edge, then withdraw valid from whoever was just accepted.
    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc_mask_last;
    endtask

    task automatic send_one(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2*W-1:0] prod);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        exp_q.push_back({IW'(id), prod});
        req_valid[id] = 1'b1;
        for (int k = 0; k < 40 && req_valid[id]; k++) tick();
        if (req_valid[id]) begin
            fail_now("accept_timeout");
            req_valid[id] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int max);
        for (int k = 0; k < max; k++) begin
            if (exp_q.size() == 0 && !rsp_valid && req_valid == '0) return;
            tick();
        end
        fail_now("idle_timeout");
    endtask

    // Monitor and scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_mask_last = '0;
        end else begin
            mon_acc       = req_valid & req_ready;
            acc_mask_last = mon_acc;
            if (!bulk) check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            for (int i = 0; i < NR; i++) begin
                if (mon_acc[i]) begin
                    acc_cnt++;
                    if (!bulk) begin
                        grant_q.push_back(i);
                        acc_cyc_q.push_back(cyc);
                    end
                end
            end
            if (rsp_valid && rsp_ready && !bulk) begin
                rsp_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    fail_now("rsp_unexpected");
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(mon_exp[EW-1:2*W]));
                    check("rsp_product", 32'(rsp_product), 32'(mon_exp[2*W-1:0]));
                end
            end
        end
    end

    initial begin
        n_tests = 0; n_fail = 0; acc_cnt = 0; bulk = 1'b0;
        acc_mask_last = '0;
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;

        vecs[0] = '{1, 4'd3,  4'd5,  8'd15};
        vecs[1] = '{2, 4'd15, 4'd15, 8'd225};
        vecs[2] = '{0, 4'd15, 4'd1,  8'd15};
        vecs[3] = '{2, 4'd8,  4'd8,  8'd64};
        vecs[4] = '{1, 4'd7,  4'd6,  8'd42};
        vecs[5] = '{3, 4'd0,  4'd9,  8'd0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_product", 32'(rsp_product), 0);
        check("rst_op_count", 32'(op_count), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        tick(); tick();

        // Single request: 10 x 12 from requester 0, exact latency
        req_a[0 +: W] = 4'd10; req_b[0 +: W] = 4'd12;
        exp_q.push_back({IW'(0), 8'd120});
        req_valid = 4'b0001;
        #1;
        check("single_ready", 32'(req_ready), 32'b0001);
        tick();
        check("single_early", 32'(rsp_valid), 0);
        tick();
        check("single_valid", 32'(rsp_valid), 1);
        check("single_product", 32'(rsp_product), 120);
        check("single_id", 32'(rsp_id), 0);
        tick();
        check("single_count", 32'(op_count), 1);
        check("single_done", 32'(rsp_valid), 0);

        // Table of single requests
        for (int v = 0; v < 6; v++) begin
            send_one(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].prod);
            wait_idle(20);
        end
        check("table_count", 32'(op_count), 7);

        // All four valid together: grants 0..3 back to back
        grant_q.delete(); acc_cyc_q.delete(); rsp_cyc_q.delete();
        req_a = {4'd0, 4'd11, 4'd15, 4'd13};
        req_b = {4'd7, 4'd9,  4'd15, 4'd12};
        exp_q.push_back({2'd0, 8'd156});
        exp_q.push_back({2'd1, 8'd225});
        exp_q.push_back({2'd2, 8'd99});
        exp_q.push_back({2'd3, 8'd0});
        req_valid = 4'b1111;
        for (int k = 0; k < 20 && req_valid != '0; k++) tick();
        wait_idle(20);
        check("quad_grants", 32'(grant_q.size()), 4);
        if (grant_q.size() == 4) begin
            for (int i = 0; i < 4; i++) check("quad_order", 32'(grant_q[i]), 32'(i));
            check("quad_accept_span", 32'(acc_cyc_q[3] - acc_cyc_q[0]), 3);
        end
        check("quad_rsp_n", 32'(rsp_cyc_q.size()), 4);
        if (rsp_cyc_q.size() == 4) check("quad_rsp_span", 32'(rsp_cyc_q[3] - rsp_cyc_q[0]), 3);
        check("quad_count", 32'(op_count), 11);

        // Backpressure: two accepts, stall, then a third requester waits
        rsp_ready = 1'b0;
        req_a[0 +: W] = 4'd3; req_b[0 +: W] = 4'd4;
        req_a[W +: W] = 4'd5; req_b[W +: W] = 4'd5;
        exp_q.push_back({2'd0, 8'd12});
        exp_q.push_back({2'd1, 8'd25});
        req_valid = 4'b0011;
        tick(); tick();
        req_a[2*W +: W] = 4'd6; req_b[2*W +: W] = 4'd2;
        req_valid[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_valid", 32'(rsp_valid), 1);
            check("stall_product", 32'(rsp_product), 12);
            check("stall_id", 32'(rsp_id), 0);
            check("stall_ready", 32'(req_ready), 0);
            tick();
        end
        check("stall_count", 32'(op_count), 11);
        rsp_cyc_q.delete();
        exp_q.push_back({2'd2, 8'd12});
        rsp_ready = 1'b1;
        for (int k = 0; k < 10 && req_valid != '0; k++) tick();
        wait_idle(20);
        check("drain_n", 32'(rsp_cyc_q.size()), 3);
        if (rsp_cyc_q.size() == 3) begin
            check("drain_gap0", 32'(rsp_cyc_q[1] - rsp_cyc_q[0]), 1);
            check("drain_gap1", 32'(rsp_cyc_q[2] - rsp_cyc_q[1]), 1);
        end
        check("drain_count", 32'(op_count), 14);

        // Fairness after idle: 2 served, then 1 and 3 together -> 3 first
        send_one(2, 4'd1, 4'd1, 8'd1);
        wait_idle(20);
        grant_q.delete();
        req_a[W +: W] = 4'd2; req_b[W +: W] = 4'd3;
        req_a[3*W +: W] = 4'd4; req_b[3*W +: W] = 4'd4;
        exp_q.push_back({2'd3, 8'd16});
        exp_q.push_back({2'd1, 8'd6});
        req_valid = 4'b1010;
        for (int k = 0; k < 10 && req_valid != '0; k++) tick();
        wait_idle(20);
        check("fair_n", 32'(grant_q.size()), 2);
        if (grant_q.size() == 2) begin
            check("fair_first", 32'(grant_q[0]), 3);
            check("fair_second", 32'(grant_q[1]), 1);
        end

        // Reset with both stages full
        rsp_ready = 1'b0;
        req_a[0 +: W] = 4'd2; req_b[0 +: W] = 4'd2;
        req_a[W +: W] = 4'd3; req_b[W +: W] = 4'd3;
        req_valid = 4'b0011;
        tick(); tick();
        check("flight_full", 32'(rsp_valid), 1);
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("flight_rsp_valid", 32'(rsp_valid), 0);
        check("flight_count", 32'(op_count), 0);
        check("flight_ready", 32'(req_ready), 0);
        exp_q.delete(); grant_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();
        req_a[0 +: W] = 4'd15; req_b[0 +: W] = 4'd15;
        req_a[3*W +: W] = 4'd1; req_b[3*W +: W] = 4'd1;
        exp_q.push_back({2'd0, 8'd225});
        exp_q.push_back({2'd3, 8'd1});
        req_valid = 4'b1001;
        #1;
        check("ptr_after_reset", 32'(req_ready), 32'b0001);
        for (int k = 0; k < 10 && req_valid != '0; k++) tick();
        wait_idle(20);
        check("post_reset_count", 32'(op_count), 2);

        // Counter wrap: bring op_count to 0xFFFF, then one more completion
        bulk = 1'b1;
        base = acc_cnt;
        req_a = '0; req_b = '0;
        req_valid = 4'b1111;
        for (int k = 0; k < 70000; k++) begin
            tick();
            if (acc_cnt - base >= 65533) break;
            req_valid = 4'b1111;
        end
        req_valid = '0;
        check("bulk_accepts", 32'(acc_cnt - base), 65533);
        repeat (4) tick();
        bulk = 1'b0;
        check("wrap_pre", 32'(op_count), 32'hFFFF);
        send_one(2, 4'd9, 4'd9, 8'd81);
        wait_idle(20);
        check("wrap_zero", 32'(op_count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
